axi_lite_master: RTL

AXI_LITE_MASTER -- requirements
Module: axi_lite_master

---
 rtl/axi_lite_master_if.sv | 28 ++
 rtl/axi_lite_master.sv | 121 ++++++++++++
 2 files changed

// File: rtl/axi_lite_master_if.sv
// AXI-lite bus bundle between a single-outstanding master and its slave.
// The master modport drives address/data valids and the response readies.
interface axi_lite_master_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
);
   logic                  awvalid, awready;
   logic [ADDR_W-1:0]     awaddr;
   logic                  wvalid, wready;
   logic [DATA_W-1:0]     wdata;
   logic [DATA_W/8-1:0]   wstrb;
   logic                  bvalid, bready;
   logic [1:0]            bresp;
   logic                  arvalid, arready;
   logic [ADDR_W-1:0]     araddr;
   logic                  rvalid, rready;
   logic [DATA_W-1:0]     rdata;
   logic [1:0]            rresp;

   modport master (
      output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );
   modport slave (
      input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );
endinterface

// File: rtl/axi_lite_master.sv
// Command/response front end issuing one AXI-lite read or write at a time.
// Define AXI_LITE_MASTER_TIMEOUT_EN to add an 8-bit per-state watchdog.
module axi_lite_master #(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 32,
   parameter int TO_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   axi_lite_master_if.master bus
);
   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] WR   = 3'd1;
   localparam logic [2:0] WB   = 3'd2;
   localparam logic [2:0] RD_A = 3'd3;
   localparam logic [2:0] RD_R = 3'd4;
   localparam logic [2:0] RSP  = 3'd5;

   logic [2:0] state, nxt;
   logic       to_hit, to_fire, aw_fin, w_fin;

   // In WR a low valid means that channel already completed.
   assign aw_fin = !bus.awvalid || bus.awready;
   assign w_fin  = !bus.wvalid  || bus.wready;

   assign cmd_ready   = (state == IDLE);
   assign rsp_valid   = (state == RSP);
   assign bus.bready  = (state == WB);
   assign bus.rready  = (state == RD_R);
   assign bus.arvalid = (state == RD_A);
   assign bus.wstrb   = '1;

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
   logic [7:0] wd;
   logic       busy;
   assign busy   = (state == WR) || (state == WB) || (state == RD_A) || (state == RD_R);
   assign to_hit = busy && (wd == 8'(TO_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                     wd <= '0;
      else if (nxt != state || !busy) wd <= '0;
      else                            wd <= wd + 8'd1;
   end
`else
   assign to_hit = 1'b0;
`endif

   always_comb begin
      nxt     = state;
      to_fire = 1'b0;
      case (state)
         IDLE:    if (cmd_valid) nxt = cmd_write ? WR : RD_A;
         WR:      if (aw_fin && w_fin) nxt = WB;
         WB:      if (bus.bvalid) nxt = RSP;
         RD_A:    if (bus.arready) nxt = RD_R;
         RD_R:    if (bus.rvalid) nxt = RSP;
         RSP:     if (rsp_ready) nxt = IDLE;
         default: nxt = IDLE;
      endcase
      // Watchdog only fires when the current state made no progress.
      if (to_hit && nxt == state) begin
         to_fire = 1'b1;
         nxt     = RSP;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         bus.awvalid <= 1'b0;
         bus.wvalid  <= 1'b0;
         bus.awaddr  <= '0;
         bus.araddr  <= '0;
         bus.wdata   <= '0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
      end else begin
         state <= nxt;
         case (state)
            IDLE: if (cmd_valid) begin
               if (cmd_write) begin
                  bus.awaddr  <= cmd_addr;
                  bus.wdata   <= cmd_wdata;
                  bus.awvalid <= 1'b1;
                  bus.wvalid  <= 1'b1;
               end else begin
                  bus.araddr  <= cmd_addr;
               end
            end
            WR: begin
               if (bus.awready) bus.awvalid <= 1'b0;
               if (bus.wready)  bus.wvalid  <= 1'b0;
            end
            WB: if (bus.bvalid) begin
               rsp_err   <= (bus.bresp != 2'b00);
               rsp_rdata <= '0;
            end
            RD_R: if (bus.rvalid) begin
               rsp_err   <= (bus.rresp != 2'b00);
               rsp_rdata <= bus.rdata;
            end
            default: ;
         endcase
         if (to_fire) begin
            bus.awvalid <= 1'b0;
            bus.wvalid  <= 1'b0;
            rsp_err     <= 1'b1;
            rsp_rdata   <= '0;
         end
      end
   end
endmodule
